divisor_norm_reg: RTL and testbench
===================================

Name: divisor_norm_reg

Overview:
Parametrised divisor operand register for the iterative unsigned divider. It captures a divisor through a valid/ready handshake and flags divide-by-zero. Optionally it left-normalises the divisor, shifting until the MSB is 1, at up to SHIFT_STEP bits per cycle, and reports the shift count. It sits between operand decode and the divider core and holds its result stable until the core consumes it.

Parameters:
WIDTH, 32, divisor width in bits; legal range 8..64.
NORMALIZE, 1, 1 = normalise before presenting; 0 = pass the captured value through unshifted.
SHIFT_STEP, 1, maximum left shift per cycle; legal values 1, 2, 4, 8; must be <= WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  div_in is valid.
in_ready  out  1  block can accept a divisor.
div_in  in  WIDTH  unsigned divisor.
out_valid  out  1  div_out, norm_shift and div_zero are valid and stable.
out_ready  in  1  divider core consumes the output.
div_out  out  WIDTH  normalised divisor, or the raw divisor when NORMALIZE=0.
norm_shift  out  SHW=$clog2(WIDTH)  number of left shifts applied.
div_zero  out  1  captured divisor was 0.
busy  out  1  block is in the NORM state.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (also reached if reset is asserted mid-operation, in any state, with in-flight data discarded): state=IDLE, div_out=0, norm_shift=0, div_zero=0, out_valid=0, busy=0.
- Handshakes:
  - A transfer happens on an edge where valid && ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational from out_ready and allows back-to-back operation with no bubble.
  - out_valid = (state==HOLD).
- FSM states: IDLE, NORM, HOLD.
- IDLE, on accept:
  - Register div_in into the working register; set norm_shift=0 and div_zero=(div_in==0).
  - If NORMALIZE==0, or div_in==0, or div_in[WIDTH-1]==1: go to HOLD.
  - Otherwise: go to NORM.
- NORM, each cycle:
  - k = number of leading zeros in the top SHIFT_STEP bits of the working register (1..SHIFT_STEP). k never exceeds the remaining leading zeros.
  - Working register <<= k; norm_shift += k.
  - If the new MSB is 1: go to HOLD. Otherwise stay in NORM.
  - in_valid is ignored in NORM (in_ready=0).
- HOLD:
  - Outputs stay frozen while out_ready==0.
  - On out_ready: if in_valid is also high, capture the new divisor exactly as in IDLE, in the same edge. Otherwise go to IDLE.
- Latency: for lz = leading zeros of the divisor, out_valid rises ceil(lz/SHIFT_STEP)+1 cycles after the accept edge. That is 1 cycle for an already-normalised, zero, or pass-through divisor.
- Output invariants:
  - norm_shift <= WIDTH-1 always.
  - div_out[WIDTH-1]==1 whenever out_valid && !div_zero && NORMALIZE.
  - div_out == 0 and norm_shift == 0 when div_zero.
- Outputs outside HOLD hold their last values; consumers qualify them with out_valid.

Decomposition:
- Shared package divider_pkg holds:
  - state enum {IDLE, NORM, HOLD};
  - a shift-width function returning $clog2(WIDTH);
  - legal SHIFT_STEP constants.
- Use one combinational sub-module, lzc_window, parametrised by SHIFT_STEP. It returns the leading-zero count of a SHIFT_STEP-bit slice, saturating at SHIFT_STEP.
- The FSM and datapath stay in divisor_norm_reg.

Test Plan:
- WIDTH=32, STEP=1, div_in=0x00000001 -> busy for 31 cycles; out_valid at cycle 32; div_out=0x80000000, norm_shift=31, div_zero=0.
- STEP=4, div_in=0x00001000 (lz=19) -> out_valid after 6 cycles; div_out=0x80000000, norm_shift=19.
- div_in=0x00000000 -> out_valid after 1 cycle; div_zero=1, norm_shift=0, div_out=0, NORM never entered.
- NORMALIZE=0, div_in=0x00000005 -> out_valid next cycle; div_out=0x00000005, norm_shift=0.
- HOLD with out_ready=0 for 5 cycles, then out_ready=1 with in_valid=1 and div_in=0x80000003 -> outputs stable during the stall; new value captured in the same edge; next output div_out=0x80000003, shift 0, with no idle cycle.
- rst pulsed for 1 cycle during NORM (STEP=1, div_in=0x00000001) -> next cycle IDLE, in_ready=1, out_valid=0, div_out=0, norm_shift=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative divider operand path.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int STEP_1 = 1;
    localparam int STEP_2 = 2;
    localparam int STEP_4 = 4;
    localparam int STEP_8 = 8;

    function automatic int shift_width(input int width);
        return $clog2(width);
    endfunction

    // Width of a leading-zero count that must also represent "whole window is zero".
    function automatic int lz_width(input int step);
        return $clog2(step + 1);
    endfunction

    function automatic bit step_is_legal(input int step);
        return (step == STEP_1) || (step == STEP_2) || (step == STEP_4) || (step == STEP_8);
    endfunction

endpackage

// File: rtl/lzc_window.sv
// Leading-zero count of a SHIFT_STEP-bit window, saturating at SHIFT_STEP when all bits are zero.
module lzc_window
    import divider_pkg::*;
#(
    parameter  int SHIFT_STEP = 1,
    localparam int CW         = lz_width(SHIFT_STEP)
) (
    input  logic [SHIFT_STEP-1:0] win_i,
    output logic [CW-1:0]         lz_o
);

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        lz_o = CW'(SHIFT_STEP);
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (win_i[i]) begin
                lz_o = CW'(SHIFT_STEP - 1 - i);
            end
        end
    end

endmodule

// File: rtl/divisor_norm_reg.sv
// Divisor operand register: captures a divisor, flags zero, optionally left-normalises it
// at up to SHIFT_STEP bits per cycle, and holds the result until the divider core takes it.
module divisor_norm_reg
    import divider_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int NORMALIZE  = 1,
    parameter  int SHIFT_STEP = 1,
    localparam int SHW        = shift_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] div_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] div_out,
    output logic [SHW-1:0]   norm_shift,
    output logic             div_zero,
    output logic             busy
);

    localparam int CW = lz_width(SHIFT_STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   shift_q, shift_d;
    logic             zero_q, zero_d;

    logic [CW-1:0]    lz_k;
    logic [WIDTH-1:0] work_shifted;
    logic             accept;

    lzc_window #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_lzc (
        .win_i (work_q[WIDTH-1 -: SHIFT_STEP]),
        .lz_o  (lz_k)
    );

    assign work_shifted = work_q << lz_k;
    assign accept       = in_valid && in_ready;

    // Reset clears data as well so a discarded operation leaves no residue on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE, HOLD: begin
                // A HOLD-state accept implies out_ready, giving bubble-free back-to-back capture.
                if (accept) begin
                    work_d  = div_in;
                    shift_d = '0;
                    zero_d  = (div_in == '0);
                    if ((NORMALIZE == 0) || (div_in == '0) || div_in[WIDTH-1]) begin
                        state_d = HOLD;
                    end else begin
                        state_d = NORM;
                    end
                end else if ((state_q == HOLD) && out_ready) begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                work_d  = work_shifted;
                shift_d = shift_q + SHW'(lz_k);
                state_d = work_shifted[WIDTH-1] ? HOLD : NORM;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        out_valid  = (state_q == HOLD);
        busy       = (state_q == NORM);
        div_out    = work_q;
        norm_shift = shift_q;
        div_zero   = zero_q;
    end

endmodule

// File: tb/tb_divisor_norm_reg.sv
// Bench for divisor_norm_reg: three instances (step 1, step 4, pass-through) checked against an arithmetic model.
module tb_divisor_norm_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [3];
    logic        ordy [3];
    logic [31:0] din  [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        dz   [3];
    logic        bsy  [3];
    logic [31:0] dout [3];
    logic [4:0]  nsh  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        divisor_norm_reg #(
            .WIDTH      (32),
            .NORMALIZE  ((g == 2) ? 0 : 1),
            .SHIFT_STEP ((g == 1) ? 4 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .div_in     (din[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .div_out    (dout[g]),
            .norm_shift (nsh[g]),
            .div_zero   (dz[g]),
            .busy       (bsy[g])
        );
    end

    function automatic int step_of(input int id);
        return (id == 1) ? 4 : 1;
    endfunction

    function automatic bit norm_of(input int id);
        return (id != 2);
    endfunction

    // Reference: count leading zeros arithmetically, derive shift, result and latency.
    function automatic int ref_lz(input logic [31:0] d);
        int n = 0;
        longint unsigned v = d;
        if (d == 32'd0) return 32;
        while (v < 64'h8000_0000) begin
            v = v * 2;
            n++;
        end
        return n;
    endfunction

    function automatic int exp_shift(input int id, input logic [31:0] d);
        if (!norm_of(id) || d == 32'd0) return 0;
        return ref_lz(d);
    endfunction

    function automatic int exp_lat(input int id, input logic [31:0] d);
        int s = exp_shift(id, d);
        return 1 + (s + step_of(id) - 1) / step_of(id);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept d on instance id and wait for out_valid, checking latency and the held result.
    task automatic to_hold(input int id, input logic [31:0] d);
        int lat;
        int s;
        s = exp_shift(id, d);
        @(negedge clk);
        chk("in_ready_idle", 64'(ir[id]), 64'd1);
        iv[id]  = 1'b1;
        din[id] = d;
        @(posedge clk);
        #1;
        iv[id]  = 1'b0;
        din[id] = $urandom;
        @(negedge clk);
        lat = 1;
        while (!ov[id] && lat < 200) begin
            chk("busy_norm", 64'(bsy[id]), 64'd1);
            chk("in_ready_norm", 64'(ir[id]), 64'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat(id, d)));
        chk("busy_hold", 64'(bsy[id]), 64'd0);
        chk("in_ready_stall", 64'(ir[id]), 64'd0);
        chk("div_out", 64'(dout[id]), 64'(d << s));
        chk("norm_shift", 64'(nsh[id]), 64'(s));
        chk("div_zero", 64'(dz[id]), 64'(d == 32'd0));
    endtask

    task automatic stall(input int id, input int n, input logic [31:0] d);
        int s;
        s = exp_shift(id, d);
        repeat (n) begin
            @(negedge clk);
            chk("stall_valid", 64'(ov[id]), 64'd1);
            chk("stall_div_out", 64'(dout[id]), 64'(d << s));
            chk("stall_shift", 64'(nsh[id]), 64'(s));
        end
    endtask

    task automatic consume(input int id);
        ordy[id] = 1'b1;
        #1;
        chk("in_ready_consume", 64'(ir[id]), 64'd1);
        @(posedge clk);
        #1;
        ordy[id] = 1'b0;
        @(negedge clk);
        chk("idle_valid", 64'(ov[id]), 64'd0);
        chk("idle_ready", 64'(ir[id]), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] dir_vals [3][4];
        dir_vals[0] = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h4000_0000};
        dir_vals[1] = '{32'h0000_1000, 32'h0000_0001, 32'h0000_0000, 32'h0FFF_FFFF};
        dir_vals[2] = '{32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0100};

        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
            din[i]  = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 64'(ir[i]), 64'd1);
            chk("rst_out_valid", 64'(ov[i]), 64'd0);
            chk("rst_div_out", 64'(dout[i]), 64'd0);
            chk("rst_shift", 64'(nsh[i]), 64'd0);
            chk("rst_zero", 64'(dz[i]), 64'd0);
            chk("rst_busy", 64'(bsy[i]), 64'd0);
        end

        // Directed values per instance, each stalled a couple of cycles before consumption.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                to_hold(i, dir_vals[i][j]);
                stall(i, 2, dir_vals[i][j]);
                consume(i);
            end
        end

        // Five-cycle stall, then consume and capture a new divisor on the same edge.
        to_hold(0, 32'h0000_0010);
        stall(0, 5, 32'h0000_0010);
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        din[0]  = 32'h8000_0003;
        #1;
        chk("b2b_in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        iv[0]   = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(ov[0]), 64'd1);
        chk("b2b_div_out", 64'(dout[0]), 64'h8000_0003);
        chk("b2b_shift", 64'(nsh[0]), 64'd0);
        chk("b2b_zero", 64'(dz[0]), 64'd0);
        consume(0);

        // Reset mid-normalisation discards the operation; in_valid is ignored while busy.
        to_hold(0, 32'h0000_0000);
        consume(0);
        @(negedge clk);
        iv[0]  = 1'b1;
        din[0] = 32'h0000_0001;
        @(posedge clk);
        #1;
        din[0] = 32'h8000_0000;
        repeat (4) @(negedge clk);
        chk("norm_busy", 64'(bsy[0]), 64'd1);
        chk("norm_ignores_in", 64'(ir[0]), 64'd0);
        iv[0] = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(ir[0]), 64'd1);
        chk("mid_rst_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_div_out", 64'(dout[0]), 64'd0);
        chk("mid_rst_shift", 64'(nsh[0]), 64'd0);
        chk("mid_rst_busy", 64'(bsy[0]), 64'd0);

        // Random divisors with a spread of leading-zero counts.
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 9) == 0) d = 32'd0;
                else d = (32'h8000_0000 | $urandom) >> $urandom_range(0, 31);
                to_hold(i, d);
                stall(i, $urandom_range(0, 3), d);
                consume(i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
